// File: rtl/ar_rr_arbiter.sv
// Round-robin arbiter: pops one non-empty AR queue per cycle into a registered valid/ready slot tagged with its source.
// One-cycle latency with zero-bubble grants while req_ready_i is high; `AR_ARB_GRANT_CNT_EN adds per-master grant counters.
module ar_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int REQ_WIDTH   = 64,
  parameter int SRC_WIDTH   = $clog2(NUM_MASTERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           q_empty_i,
  input  logic [NUM_MASTERS*REQ_WIDTH-1:0] q_data_i,
  output logic [NUM_MASTERS-1:0]           q_pop_o,
  output logic                             req_valid_o,
  input  logic                             req_ready_i,
  output logic [REQ_WIDTH-1:0]             req_data_o,
  output logic [SRC_WIDTH-1:0]             req_src_o
`ifdef AR_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_MASTERS*16-1:0]        grant_cnt_o
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SRC_WIDTH-1:0]   r_last_grant;
  logic [SRC_WIDTH-1:0]   w_winner;
  logic                   w_any;
  logic                   w_load;
  logic [NUM_MASTERS-1:0] w_pop;
  logic [REQ_WIDTH-1:0]   w_q_data [NUM_MASTERS];

  genvar g;
  for (g = 0; g < NUM_MASTERS; g++) begin : g_slice
    assign w_q_data[g] = q_data_i[g*REQ_WIDTH +: REQ_WIDTH];
  end

  // Scan farthest-first so the nearest non-empty queue after last_grant wins.
  always_comb begin : winner_search
    logic [SRC_WIDTH-1:0] v_idx;
    w_winner = '0;
    w_any    = 1'b0;
    v_idx    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      v_idx = SRC_WIDTH'((int'(r_last_grant) + i) % NUM_MASTERS);
      if (!q_empty_i[v_idx]) begin
        w_winner = v_idx;
        w_any    = 1'b1;
      end
    end
  end

  assign w_load = (r_state == IDLE) || req_ready_i;

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_pop       = '0;
    if (w_load) begin
      if (w_any) begin
        w_state_nxt     = HOLD;
        w_pop[w_winner] = 1'b1;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  assign q_pop_o     = reset ? '0 : w_pop;
  assign req_valid_o = (r_state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= SRC_WIDTH'(NUM_MASTERS - 1);
      req_data_o   <= '0;
      req_src_o    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load && w_any) begin
        req_data_o   <= w_q_data[w_winner];
        req_src_o    <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

`ifdef AR_ARB_GRANT_CNT_EN
  logic [15:0] r_grant_cnt [NUM_MASTERS];

  // Saturating: a counter parks at 16'hFFFF instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUM_MASTERS; m++) r_grant_cnt[m] <= '0;
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (w_pop[m] && (r_grant_cnt[m] != 16'hFFFF)) r_grant_cnt[m] <= r_grant_cnt[m] + 16'd1;
      end
    end
  end

  for (g = 0; g < NUM_MASTERS; g++) begin : g_cnt
    assign grant_cnt_o[g*16 +: 16] = r_grant_cnt[g];
  end
`else
  // Grant counters are not built in this configuration.
`endif

endmodule
